// File: rtl/rr_packet_tx.sv
// rr_packet_tx
//   Buffers RR-period / R-peak-location events from the QRS detection core in
//   a small FIFO and serialises each one into a 7-byte packet on a byte-wide
//   valid/ready stream:
//     A5, rr[15:8], rr[7:0], loc[23:16], loc[15:8], loc[7:0], xor(B1..B5)
//
// Ports
//   i_clk, i_nrst         clock, synchronous active-low reset
//   i_ce                  clock enable; when low all state holds
//   i_rr_period           RR period (DATA_WIDTH bits)
//   i_rr_period_updated   one-cycle strobe: new event present
//   i_r_peak_location     R-peak sample counter (CTR_WIDTH bits)
//   o_tx_data/o_tx_valid  output byte stream, i_tx_ready is the sink's ready
//   o_busy                a packet is in flight
//   o_fifo_level          occupied FIFO entries
//   o_overflow_cnt        dropped events, saturating at 255
module rr_packet_tx #(
    parameter int DATA_WIDTH = 11,
    parameter int CTR_WIDTH  = 22,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          i_clk,
    input  logic                          i_nrst,
    input  logic                          i_ce,
    input  logic [DATA_WIDTH-1:0]         i_rr_period,
    input  logic                          i_rr_period_updated,
    input  logic [CTR_WIDTH-1:0]          i_r_peak_location,
    output logic [7:0]                    o_tx_data,
    output logic                          o_tx_valid,
    input  logic                          i_tx_ready,
    output logic                          o_busy,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
    output logic [7:0]                    o_overflow_cnt
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int EV_W  = DATA_WIDTH + CTR_WIDTH;
    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

    state_t            state_q, state_d;
    logic [2:0]        idx_q, idx_d;
    logic [7:0]        tx_data_q, tx_data_d;
    // Bytes B1..B6 still to be sent, next one in the top byte.
    logic [47:0]       pkt_q, pkt_d;

    logic [EV_W-1:0]   mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic [7:0]        ovf_q, ovf_d;

    logic              full, pop, push, xfer;
    logic [EV_W-1:0]   head;
    logic [15:0]       rr16;
    logic [23:0]       loc24;
    logic [7:0]        csum;

    // FIFO control. A full FIFO still accepts a push when the FSM pops in
    // the same cycle, so the push qualifier looks at pop.
    always_comb begin
        full     = (level_q == LVL_W'(FIFO_DEPTH));
        pop      = i_ce && (state_q == IDLE) && (level_q != '0);
        push     = i_ce && i_rr_period_updated && (!full || pop);
        xfer     = i_ce && (state_q == SEND) && i_tx_ready;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ovf_d    = ovf_q;

        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase

        if (i_ce && i_rr_period_updated && !push && (ovf_q != 8'hFF))
            ovf_d = ovf_q + 8'd1;
    end

    // Zero-extend the head entry to the packet field widths.
    always_comb begin
        head                    = mem_q[rd_ptr_q];
        rr16                    = '0;
        rr16[DATA_WIDTH-1:0]    = head[EV_W-1:CTR_WIDTH];
        loc24                   = '0;
        loc24[CTR_WIDTH-1:0]    = head[CTR_WIDTH-1:0];
        csum = rr16[15:8] ^ rr16[7:0] ^ loc24[23:16] ^ loc24[15:8] ^ loc24[7:0];
    end

    // Packet FSM next-state. tx_data is registered: B0 is loaded on the pop,
    // each later byte is loaded from pkt_q on the transfer of its predecessor.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        tx_data_d = tx_data_q;
        pkt_d     = pkt_q;

        case (state_q)
            IDLE: begin
                if (pop) begin
                    state_d   = SEND;
                    idx_d     = 3'd0;
                    tx_data_d = SYNC_BYTE;
                    pkt_d     = {rr16, loc24, csum};
                end
            end
            SEND: begin
                if (xfer) begin
                    if (idx_q == 3'd6) begin
                        state_d   = IDLE;
                        idx_d     = 3'd0;
                        tx_data_d = 8'h00;
                    end else begin
                        idx_d     = idx_q + 3'd1;
                        tx_data_d = pkt_q[47:40];
                        pkt_d     = {pkt_q[39:0], 8'h00};
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_nrst) begin
            state_q   <= IDLE;
            idx_q     <= 3'd0;
            tx_data_q <= 8'h00;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            ovf_q     <= 8'h00;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            tx_data_q <= tx_data_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            ovf_q     <= ovf_d;
        end
    end

    // Data storage needs no reset: entries are only read when level_q says so.
    always_ff @(posedge i_clk) begin
        pkt_q <= pkt_d;
        if (push) mem_q[wr_ptr_q] <= {i_rr_period, i_r_peak_location};
    end

    assign o_tx_data      = tx_data_q;
    assign o_tx_valid     = (state_q == SEND);
    assign o_busy         = (state_q == SEND);
    assign o_fifo_level   = level_q;
    assign o_overflow_cnt = ovf_q;

endmodule

// File: tb/tb_rr_packet_tx.sv
module tb_rr_packet_tx;

    localparam int DW    = 11;
    localparam int CW    = 22;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          nrst, ce, upd, ready;
    logic [DW-1:0] rr;
    logic [CW-1:0] loc;
    logic [7:0]    tx_data;
    logic          tx_valid, busy;
    logic [2:0]    level;
    logic [7:0]    ovf;

    rr_packet_tx #(.DATA_WIDTH(DW), .CTR_WIDTH(CW), .FIFO_DEPTH(DEPTH)) dut (
        .i_clk(clk), .i_nrst(nrst), .i_ce(ce),
        .i_rr_period(rr), .i_rr_period_updated(upd), .i_r_peak_location(loc),
        .o_tx_data(tx_data), .o_tx_valid(tx_valid), .i_tx_ready(ready),
        .o_busy(busy), .o_fifo_level(level), .o_overflow_cnt(ovf)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: a queue of pending events, the bytes of the packet in
    // flight, and a log of every byte the sink accepted.
    logic [39:0] mq [$];
    logic [7:0]  cur [$];
    logic [7:0]  xlog [$];
    int          m_ovf = 0;
    int          exp_data = 0;  // -1: o_tx_data unconstrained while idle

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        logic [39:0] ev;
        logic [7:0]  b [7];
        bit          do_pop;
        if (!nrst) begin
            mq.delete(); cur.delete(); m_ovf = 0; exp_data = 0;
        end else if (ce) begin
            do_pop = (cur.size() == 0) && (mq.size() > 0);
            if (cur.size() != 0 && ready) begin
                xlog.push_back(cur.pop_front());
                if (cur.size() == 0) exp_data = -1;
            end
            if (do_pop) begin
                ev   = mq.pop_front();
                b[0] = 8'hA5;
                b[1] = ev[39:32]; b[2] = ev[31:24];
                b[3] = ev[23:16]; b[4] = ev[15:8]; b[5] = ev[7:0];
                b[6] = b[1] ^ b[2] ^ b[3] ^ b[4] ^ b[5];
                for (int i = 0; i < 7; i++) cur.push_back(b[i]);
            end
            if (upd) begin
                if (mq.size() < DEPTH) mq.push_back({16'(rr), 24'(loc)});
                else if (m_ovf < 255) m_ovf++;
            end
        end
    endtask

    task automatic check_outputs();
        chk("valid", 32'(tx_valid), 32'(cur.size() != 0));
        chk("busy",  32'(busy),     32'(cur.size() != 0));
        chk("level", 32'(level),    32'(mq.size()));
        chk("ovf",   32'(ovf),      32'(m_ovf));
        if (cur.size() != 0)    chk("data", 32'(tx_data), 32'(cur[0]));
        else if (exp_data >= 0) chk("data_idle", 32'(tx_data), 32'(exp_data));
    endtask

    // One clock: DUT and model advance on the same edge, outputs checked on
    // the falling edge; inputs are changed only after the check.
    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic strobe(input logic [DW-1:0] r, input logic [CW-1:0] l);
        rr = r; loc = l; upd = 1'b1;
        cyc();
        upd = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((cur.size() != 0 || mq.size() != 0) && n < budget) begin
            cyc(); n++;
        end
        chk("drain_timeout", 32'(cur.size() + mq.size()), 32'd0);
    endtask

    logic [7:0] exp_pkt [7] = '{8'hA5, 8'h02, 8'hA3, 8'h01, 8'h23, 8'h45, 8'hC6};
    int         busy_cnt, n, lvl_save, ovf_save;
    logic [7:0] data_save;
    bit         done;

    initial begin
        nrst = 1'b0; ce = 1'b1; upd = 1'b0; ready = 1'b1; rr = '0; loc = '0;
        @(negedge clk);
        cyc(); cyc();
        chk("rst_valid", 32'(tx_valid), 32'd0);
        chk("rst_data",  32'(tx_data),  32'd0);
        chk("rst_level", 32'(level),    32'd0);
        nrst = 1'b1;
        cyc();

        // Single event, latency and exact byte sequence.
        xlog.delete();
        strobe(11'h2A3, 22'h12345);
        chk("lat_n1", 32'(tx_valid), 32'd0);
        cyc();
        chk("lat_n2", 32'(tx_valid), 32'd1);
        busy_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (busy) busy_cnt++;
            cyc();
        end
        chk("busy_cycles", 32'(busy_cnt), 32'd7);
        chk("pkt_len", 32'(xlog.size()), 32'd7);
        for (int i = 0; i < 7 && i < xlog.size(); i++)
            chk("pkt_byte", 32'(xlog[i]), 32'(exp_pkt[i]));

        // Backpressure on the same event.
        xlog.delete();
        strobe(11'h2A3, 22'h12345);
        n = 0;
        while (xlog.size() < 7 && n < 200) begin
            ready = $urandom_range(0, 1);
            cyc(); n++;
        end
        ready = 1'b1;
        cyc();
        chk("bp_len", 32'(xlog.size()), 32'd7);
        for (int i = 0; i < 7 && i < xlog.size(); i++)
            chk("bp_byte", 32'(xlog[i]), 32'(exp_pkt[i]));

        // Overflow: ready low, six strobes rr=1..6.
        ready = 1'b0;
        xlog.delete();
        for (int i = 1; i <= 6; i++) strobe(DW'(i), CW'(i * 1000));
        chk("ovf_level", 32'(level), 32'd4);
        chk("ovf_cnt",   32'(ovf),   32'd1);
        ready = 1'b1;
        drain(100);
        cyc();
        chk("ovf_xfer_len", 32'(xlog.size()), 32'd35);
        for (int p = 0; p < 5 && xlog.size() >= 35; p++)
            chk("ovf_order", 32'(xlog[p * 7 + 2]), 32'(p + 1));

        // Full FIFO with a strobe on the cycle of the IDLE pop.
        ready = 1'b0;
        for (int i = 0; i < 5; i++) strobe(DW'(16 + i), CW'(i));
        ready = 1'b1;
        ovf_save = int'(ovf);
        done = 1'b0;
        n = 0;
        while (!done && n < 50) begin
            if (cur.size() == 0 && mq.size() == DEPTH) begin
                strobe(11'h7FF, 22'h3FFFFF);
                done = 1'b1;
                chk("fullpop_level", 32'(level), 32'd4);
                chk("fullpop_ovf",   32'(ovf),   32'(ovf_save));
            end else cyc();
            n++;
        end
        chk("fullpop_reached", 32'(done), 32'd1);
        drain(200);

        // Clock enable low for 3 cycles mid-packet, strobe during it.
        strobe(11'h155, 22'h2AAAA);
        cyc(); cyc(); cyc();
        lvl_save = int'(level);
        data_save = tx_data;
        ce = 1'b0;
        cyc();
        strobe(11'h0F0, 22'h00F0F);
        cyc();
        chk("ce_level", 32'(level), 32'(lvl_save));
        chk("ce_data",  32'(tx_data), 32'(data_save));
        ce = 1'b1;
        drain(100);

        // Reset mid-packet with two events queued.
        strobe(11'h321, 22'h054321);
        strobe(11'h001, 22'h000001);
        strobe(11'h002, 22'h000002);
        xlog.delete();
        n = 0;
        while (xlog.size() < 4 && n < 50) begin cyc(); n++; end
        chk("rst_mid_reached", 32'(xlog.size()), 32'd4);
        nrst = 1'b0;
        cyc();
        nrst = 1'b1;
        chk("rstm_valid", 32'(tx_valid), 32'd0);
        chk("rstm_busy",  32'(busy),     32'd0);
        chk("rstm_data",  32'(tx_data),  32'd0);
        chk("rstm_level", 32'(level),    32'd0);
        chk("rstm_ovf",   32'(ovf),      32'd0);
        xlog.delete();
        strobe(11'h2A3, 22'h12345);
        drain(50);
        cyc();
        chk("rstm_len", 32'(xlog.size()), 32'd7);
        if (xlog.size() > 0) chk("rstm_b0", 32'(xlog[0]), 32'hA5);

        // Randomised traffic against the model.
        for (int seg = 0; seg < 4; seg++) begin
            for (int i = 0; i < 800; i++) begin
                ce    = ($urandom_range(0, 9) != 0);
                upd   = ($urandom_range(0, 99) < (seg * 10 + 8));
                ready = ($urandom_range(0, 9) < (seg == 2 ? 2 : 7));
                nrst  = ($urandom_range(0, 299) != 0);
                rr    = DW'($urandom);
                loc   = CW'($urandom);
                cyc();
            end
        end
        nrst = 1'b1; upd = 1'b0; ce = 1'b1; ready = 1'b1;
        drain(200);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
